// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the cv32e40p load/store unit.
// Optional feature macro used by the LSU: CV32E40P_LSU_MISALIGNED_EN.
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    LSU_WORD = 2'b00,
    LSU_HALF = 2'b01,
    LSU_BYTE = 2'b10
  } lsu_type_e;

  typedef enum logic {
    LSU_IDLE   = 1'b0,
    LSU_SECOND = 1'b1
  } lsu_state_e;

  // Bookkeeping needed to post-process one bus response
  typedef struct packed {
    logic      we;
    lsu_type_e lsu_type;
    logic      sign;
    logic [1:0] off;
    logic      final_part;
  } lsu_resp_t;

  localparam logic [3:0] LSU_BE_WORD = 4'b1111;
  localparam logic [3:0] LSU_BE_HALF = 4'b0011;
  localparam logic [3:0] LSU_BE_BYTE = 4'b0001;

  // An access is misaligned when it would straddle a word boundary;
  // the unused 2'b11 encoding behaves like a word
  function automatic logic lsu_misaligned(lsu_type_e t, logic [1:0] off);
    logic word_like;
    word_like = (t != LSU_HALF) && (t != LSU_BYTE);
    return (word_like && (off != 2'b00)) || ((t == LSU_HALF) && (off == 2'b11));
  endfunction

endpackage

// File: rtl/cv32e40p_lsu_resp_fifo.sv
// In-order FIFO of outstanding-response descriptors; pop and push in the
// same cycle is legal even when full.
module cv32e40p_lsu_resp_fifo
  import cv32e40p_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  lsu_resp_t push_data,
  output lsu_resp_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  lsu_resp_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  // Descriptor storage, written on accepted push
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cv32e40p_load_store_unit.sv
// Data-memory load/store unit: drives the OBI data bus from EX requests,
// tracks outstanding transactions and returns aligned, extended load data.
// Define CV32E40P_LSU_MISALIGNED_EN to split word-crossing accesses into two
// bus transactions; otherwise they are rejected via lsu_misaligned_o.
module cv32e40p_load_store_unit
  import cv32e40p_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_en_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_type_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_rvalid_o,
  output logic        lsu_err_o,
  output logic        lsu_misaligned_o,
  output logic        lsu_ready_ex_o,
  output logic        lsu_ready_wb_o,
  output logic        busy_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  input  logic [31:0] data_rdata_i
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  lsu_type_e        lsu_type;
  logic [1:0]       off;
  logic [CNT_W-1:0] cnt;
  lsu_state_e       state;
  logic [31:0]      partial_word;
  logic             split_pending;
  logic             err_acc;
  logic             misaligned;
  logic             split;
  logic             reject;
  logic             final_part;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [3:0]       be_base;
  logic [7:0]       be_wide;
  logic [31:0]      rdata_lo;
  logic [31:0]      rdata_rot;
  logic [31:0]      rdata_ext;
  lsu_resp_t        push_entry;
  lsu_resp_t        head;

  assign lsu_type   = lsu_type_e'(lsu_type_i);
  assign off        = lsu_addr_i[1:0];
  assign misaligned = lsu_misaligned(lsu_type, off);

`ifdef CV32E40P_LSU_MISALIGNED_EN
  assign split  = lsu_en_i & misaligned & (state == LSU_IDLE);
  assign reject = 1'b0;
`else
  assign split  = 1'b0;
  assign reject = lsu_en_i & misaligned;
`endif

  // The second half of a split access is always the final one
  assign final_part = ~split;
  // fifo_full mirrors cnt==DEPTH; keeping both guards the FIFO from overflow
  assign data_req_o = lsu_en_i & ~reject & (cnt < CNT_W'(DEPTH)) & ~fifo_full;
  assign push       = data_req_o & data_gnt_i;
  assign pop        = data_rvalid_i & ~fifo_empty;

  // Byte enables spanning up to two words, indexed by the byte offset
  always_comb begin
    case (lsu_type)
      LSU_HALF: be_base = LSU_BE_HALF;
      LSU_BYTE: be_base = LSU_BE_BYTE;
      default:  be_base = LSU_BE_WORD;
    endcase
    be_wide = {4'b0000, be_base} << off;
  end

  assign data_we_o    = lsu_we_i;
  // Rotate left by 8*off, written as a right shift of the doubled word
  assign data_wdata_o = 32'({lsu_wdata_i, lsu_wdata_i} >> (6'd32 - {1'b0, off, 3'b000}));
  assign data_addr_o  = (state == LSU_SECOND) ? {lsu_addr_i[31:2] + 30'd1, 2'b00}
                                              : {lsu_addr_i[31:2], 2'b00};
  assign data_be_o    = (state == LSU_SECOND) ? be_wide[7:4] : be_wide[3:0];

  // Descriptor recorded for each granted transaction
  always_comb begin
    push_entry            = '0;
    push_entry.we         = lsu_we_i;
    push_entry.lsu_type   = lsu_type;
    push_entry.sign       = lsu_sign_ext_i;
    push_entry.off        = off;
    push_entry.final_part = final_part;
  end

  cv32e40p_lsu_resp_fifo #(
    .DEPTH(DEPTH)
  ) u_resp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .push_data(push_entry),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Realign response data (merging a held first half) and extend it
  always_comb begin
    rdata_lo  = split_pending ? partial_word : data_rdata_i;
    rdata_rot = 32'({data_rdata_i, rdata_lo} >> {head.off, 3'b000});
    case (head.lsu_type)
      LSU_BYTE: rdata_ext = {{24{head.sign & rdata_rot[7]}}, rdata_rot[7:0]};
      LSU_HALF: rdata_ext = {{16{head.sign & rdata_rot[15]}}, rdata_rot[15:0]};
      default:  rdata_ext = rdata_rot;
    endcase
  end

  assign lsu_rvalid_o     = pop & head.final_part;
  assign lsu_rdata_o      = (lsu_rvalid_o & ~head.we) ? rdata_ext : 32'h0000_0000;
  assign lsu_err_o        = lsu_rvalid_o & (data_err_i | err_acc);
  assign lsu_misaligned_o = reject;
  assign lsu_ready_ex_o   = ~lsu_en_i | (push & final_part) | reject;
  assign lsu_ready_wb_o   = (cnt == '0) |
                            (pop & head.final_part & (cnt == CNT_W'(1)) & ~push);
  assign busy_o           = (cnt != '0) | (state != LSU_IDLE);

  // Outstanding-transaction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Split-access sequencer: SECOND issues the upper word
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LSU_IDLE;
    end else begin
      case (state)
        LSU_IDLE:   state <= (push & split) ? LSU_SECOND : LSU_IDLE;
        LSU_SECOND: state <= push ? LSU_IDLE : LSU_SECOND;
        default:    state <= LSU_IDLE;
      endcase
    end
  end

  // Hold the first-half response of a split access until the second arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      partial_word  <= 32'h0000_0000;
      split_pending <= 1'b0;
      err_acc       <= 1'b0;
    end else if (pop & ~head.final_part) begin
      partial_word  <= data_rdata_i;
      split_pending <= 1'b1;
      err_acc       <= data_err_i;
    end else if (pop) begin
      split_pending <= 1'b0;
      err_acc       <= 1'b0;
    end else begin
      split_pending <= split_pending;
      err_acc       <= err_acc;
    end
  end

endmodule

// File: tb/tb_cv32e40p_load_store_unit.sv
// Randomized and directed bench for cv32e40p_load_store_unit with a
// byte-level reference model of alignment, byte enables and extension.
module tb_cv32e40p_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lsu_en_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [1:0]  lsu_type_i = 2'b00;
  logic        lsu_sign_ext_i = 1'b0;
  logic [31:0] lsu_addr_i = 32'h0;
  logic [31:0] lsu_wdata_i = 32'h0;
  logic [31:0] lsu_rdata_o;
  logic        lsu_rvalid_o;
  logic        lsu_err_o;
  logic        lsu_misaligned_o;
  logic        lsu_ready_ex_o;
  logic        lsu_ready_wb_o;
  logic        busy_o;
  logic        data_req_o;
  logic        data_gnt_i = 1'b0;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i = 1'b0;
  logic        data_err_i = 1'b0;
  logic [31:0] data_rdata_i = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cv32e40p_load_store_unit #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .lsu_en_i(lsu_en_i), .lsu_we_i(lsu_we_i),
    .lsu_type_i(lsu_type_i), .lsu_sign_ext_i(lsu_sign_ext_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_rdata_o(lsu_rdata_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_err_o(lsu_err_o),
    .lsu_misaligned_o(lsu_misaligned_o), .lsu_ready_ex_o(lsu_ready_ex_o),
    .lsu_ready_wb_o(lsu_ready_wb_o), .busy_o(busy_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i), .data_rdata_i(data_rdata_i)
  );

  // ---------------- reference model ----------------
  function automatic int size_of(logic [1:0] t);
    if (t == 2'b10) return 1;
    if (t == 2'b01) return 2;
    return 4;
  endfunction

  // Byte lanes touched in the lower (hi=0) or upper (hi=1) word
  function automatic logic [3:0] m_be(logic [1:0] t, logic [1:0] off, bit hi);
    logic [3:0] be = 4'b0000;
    for (int i = 0; i < size_of(t); i++) begin
      int idx = int'(off) + i;
      if (!hi && idx < 4) be[idx] = 1'b1;
      if (hi && idx >= 4) be[idx - 4] = 1'b1;
    end
    return be;
  endfunction

  // Store byte i lands on lane (off+i) mod 4
  function automatic logic [31:0] m_wdata(logic [31:0] w, logic [1:0] off);
    logic [31:0] r = 32'h0;
    for (int i = 0; i < 4; i++) r[8*((i + int'(off)) % 4) +: 8] = w[8*i +: 8];
    return r;
  endfunction

  // Bytes starting at 'off' in the little-endian 8-byte window {hi,lo}
  function automatic logic [31:0] m_load(logic [1:0] t, logic sgn, logic [1:0] off,
                                         logic [63:0] pair);
    logic [31:0] v = 32'h0;
    int n = size_of(t);
    for (int i = 0; i < n; i++) v[8*i +: 8] = pair[8*(int'(off) + i) +: 8];
    if (sgn && n < 4 && v[8*n - 1])
      for (int j = n; j < 4; j++) v[8*j +: 8] = 8'hFF;
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lsu_en_i = 1'b0; lsu_we_i = 1'b0; data_gnt_i = 1'b0;
    data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = 32'h0;
  endtask

  task automatic access(logic we, logic [1:0] t, logic sgn, logic [31:0] a, logic [31:0] w);
    lsu_en_i = 1'b1; lsu_we_i = we; lsu_type_i = t; lsu_sign_ext_i = sgn;
    lsu_addr_i = a; lsu_wdata_i = w;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle(); rst = 1'b1;
    tick(); tick();
    rst = 1'b0; #1;
    checks++; if (data_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got=%b want=0", data_req_o); end
    checks++; if (lsu_rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b want=0", lsu_rvalid_o); end
    checks++; if (lsu_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", lsu_err_o); end
    checks++; if (lsu_misaligned_o !== 1'b0) begin errors++; $display("FAIL reset_mis got=%b want=0", lsu_misaligned_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    checks++; if (lsu_ready_ex_o !== 1'b1) begin errors++; $display("FAIL reset_ready_ex got=%b want=1", lsu_ready_ex_o); end
    checks++; if (lsu_ready_wb_o !== 1'b1) begin errors++; $display("FAIL reset_ready_wb got=%b want=1", lsu_ready_wb_o); end
  endtask

  task automatic test_load_word();
    logic [31:0] rd = 32'hDEADBEEF;
    tick();
    access(1'b0, 2'b00, 1'b0, 32'h100, 32'h0); data_gnt_i = 1'b1; #1;
    checks++; if (data_req_o !== 1'b1) begin errors++; $display("FAIL lw_req got=%b want=1", data_req_o); end
    checks++; if (data_addr_o !== 32'h100) begin errors++; $display("FAIL lw_addr got=%h want=00000100", data_addr_o); end
    checks++; if (data_be_o !== 4'b1111) begin errors++; $display("FAIL lw_be got=%b want=1111", data_be_o); end
    checks++; if (lsu_ready_ex_o !== 1'b1) begin errors++; $display("FAIL lw_ready_ex got=%b want=1", lsu_ready_ex_o); end
    tick(); idle(); #1;
    checks++; if (lsu_ready_wb_o !== 1'b0) begin errors++; $display("FAIL lw_ready_wb_pend got=%b want=0", lsu_ready_wb_o); end
    data_rvalid_i = 1'b1; data_rdata_i = rd; #1;
    checks++; if (lsu_rvalid_o !== 1'b1) begin errors++; $display("FAIL lw_rvalid got=%b want=1", lsu_rvalid_o); end
    checks++; if (lsu_rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got=%h want=deadbeef", lsu_rdata_o); end
    checks++; if (lsu_ready_wb_o !== 1'b1) begin errors++; $display("FAIL lw_ready_wb_done got=%b want=1", lsu_ready_wb_o); end
    tick(); idle(); #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL lw_busy_after got=%b want=0", busy_o); end
  endtask

  task automatic test_byte_loads();
    for (int s = 1; s >= 0; s--) begin
      logic [31:0] want;
      access(1'b0, 2'b10, s[0], 32'h103, 32'h0); data_gnt_i = 1'b1; #1;
      checks++; if (data_be_o !== 4'b1000) begin errors++; $display("FAIL lb_be got=%b want=1000", data_be_o); end
      tick(); idle();
      data_rvalid_i = 1'b1; data_rdata_i = 32'h80FF_FF00; #1;
      want = (s == 1) ? 32'hFFFF_FF80 : 32'h0000_0080;
      checks++; if (lsu_rdata_o !== want) begin errors++; $display("FAIL lb_rdata sign=%0d got=%h want=%h", s, lsu_rdata_o, want); end
      tick(); idle();
    end
  endtask

  task automatic test_store_half();
    access(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_1234); data_gnt_i = 1'b1; #1;
    checks++; if (data_be_o !== 4'b1100) begin errors++; $display("FAIL sh_be got=%b want=1100", data_be_o); end
    checks++; if (data_wdata_o !== 32'h1234_0000) begin errors++; $display("FAIL sh_wdata got=%h want=12340000", data_wdata_o); end
    checks++; if (data_we_o !== 1'b1) begin errors++; $display("FAIL sh_we got=%b want=1", data_we_o); end
    tick(); idle();
    data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFF_FFFF; #1;
    checks++; if (lsu_rvalid_o !== 1'b1 || lsu_rdata_o !== 32'h0)
      begin errors++; $display("FAIL sh_resp got=%b/%h want=1/00000000", lsu_rvalid_o, lsu_rdata_o); end
    tick(); idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd [3];
    for (int i = 0; i < 3; i++) rd[i] = $urandom;
    access(1'b0, 2'b00, 1'b0, 32'h200, 32'h0); data_gnt_i = 1'b1; #1;
    checks++; if (data_req_o !== 1'b1 || lsu_ready_ex_o !== 1'b1) begin errors++; $display("FAIL b2b_first got=%b%b want=11", data_req_o, lsu_ready_ex_o); end
    tick(); lsu_addr_i = 32'h204; #1;
    checks++; if (data_req_o !== 1'b1 || lsu_ready_ex_o !== 1'b1) begin errors++; $display("FAIL b2b_second got=%b%b want=11", data_req_o, lsu_ready_ex_o); end
    tick(); lsu_addr_i = 32'h208; #1;
    for (int c = 0; c < 2; c++) begin
      checks++; if (data_req_o !== 1'b0 || lsu_ready_ex_o !== 1'b0) begin errors++; $display("FAIL b2b_third_held got=%b%b want=00", data_req_o, lsu_ready_ex_o); end
      tick();
    end
    data_rvalid_i = 1'b1; data_rdata_i = rd[0]; #1;
    checks++; if (lsu_rdata_o !== rd[0] || data_req_o !== 1'b0) begin errors++; $display("FAIL b2b_resp0 got=%h/%b want=%h/0", lsu_rdata_o, data_req_o, rd[0]); end
    tick(); data_rvalid_i = 1'b0; #1;
    checks++; if (data_req_o !== 1'b1 || lsu_ready_ex_o !== 1'b1 || data_addr_o !== 32'h208)
      begin errors++; $display("FAIL b2b_third_issue got=%b%b %h want=11 00000208", data_req_o, lsu_ready_ex_o, data_addr_o); end
    tick(); idle();
    for (int i = 1; i < 3; i++) begin
      data_rvalid_i = 1'b1; data_rdata_i = rd[i]; #1;
      checks++; if (lsu_rvalid_o !== 1'b1 || lsu_rdata_o !== rd[i]) begin errors++; $display("FAIL b2b_resp%0d got=%b/%h want=1/%h", i, lsu_rvalid_o, lsu_rdata_o, rd[i]); end
      tick();
    end
    idle(); #1;
    checks++; if (busy_o !== 1'b0 || lsu_ready_wb_o !== 1'b1) begin errors++; $display("FAIL b2b_drained got=%b%b want=01", busy_o, lsu_ready_wb_o); end
  endtask

  task automatic test_misaligned();
`ifdef CV32E40P_LSU_MISALIGNED_EN
    logic [31:0] want = m_load(2'b00, 1'b0, 2'b11, {32'h88776655, 32'h44332211});
    access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0); data_gnt_i = 1'b1; #1;
    checks++; if (data_addr_o !== 32'h100 || data_be_o !== m_be(2'b00, 2'b11, 1'b0) || lsu_ready_ex_o !== 1'b0)
      begin errors++; $display("FAIL split_first got=%h %b %b want=00000100 %b 0", data_addr_o, data_be_o, lsu_ready_ex_o, m_be(2'b00, 2'b11, 1'b0)); end
    tick();
    checks++; if (data_addr_o !== 32'h104 || data_be_o !== m_be(2'b00, 2'b11, 1'b1) || lsu_ready_ex_o !== 1'b1)
      begin errors++; $display("FAIL split_second got=%h %b %b want=00000104 %b 1", data_addr_o, data_be_o, lsu_ready_ex_o, m_be(2'b00, 2'b11, 1'b1)); end
    tick(); idle();
    data_rvalid_i = 1'b1; data_rdata_i = 32'h44332211; #1;
    checks++; if (lsu_rvalid_o !== 1'b0) begin errors++; $display("FAIL split_part1_rvalid got=%b want=0", lsu_rvalid_o); end
    tick(); data_rdata_i = 32'h88776655; #1;
    checks++; if (lsu_rvalid_o !== 1'b1 || lsu_rdata_o !== want || want !== 32'h77665544)
      begin errors++; $display("FAIL split_merge got=%b/%h want=1/77665544", lsu_rvalid_o, lsu_rdata_o); end
    tick(); idle();
`else
    logic [31:0] rd = $urandom;
    access(1'b0, 2'b00, 1'b0, 32'h101, 32'h0); data_gnt_i = 1'b1; #1;
    checks++; if (data_req_o !== 1'b0 || lsu_misaligned_o !== 1'b1 || lsu_ready_ex_o !== 1'b1)
      begin errors++; $display("FAIL mis_lw got=%b%b%b want=011", data_req_o, lsu_misaligned_o, lsu_ready_ex_o); end
    tick();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mis_busy got=%b want=0", busy_o); end
    access(1'b0, 2'b01, 1'b0, 32'h103, 32'h0); #1;
    checks++; if (data_req_o !== 1'b0 || lsu_misaligned_o !== 1'b1) begin errors++; $display("FAIL mis_lh got=%b%b want=01", data_req_o, lsu_misaligned_o); end
    access(1'b0, 2'b01, 1'b1, 32'h101, 32'h0); #1;
    checks++; if (data_req_o !== 1'b1 || lsu_misaligned_o !== 1'b0 || data_be_o !== m_be(2'b01, 2'b01, 1'b0))
      begin errors++; $display("FAIL mis_lh_ok got=%b%b %b want=10 0110", data_req_o, lsu_misaligned_o, data_be_o); end
    tick(); idle();
    data_rvalid_i = 1'b1; data_rdata_i = rd; #1;
    checks++; if (lsu_rdata_o !== m_load(2'b01, 1'b1, 2'b01, {rd, rd}))
      begin errors++; $display("FAIL mis_lh_rdata got=%h want=%h", lsu_rdata_o, m_load(2'b01, 1'b1, 2'b01, {rd, rd})); end
    tick(); idle();
`endif
  endtask

  task automatic test_error();
    access(1'b0, 2'b00, 1'b0, 32'h400, 32'h0); data_gnt_i = 1'b1;
    tick(); idle();
    data_rvalid_i = 1'b1; data_err_i = 1'b1; data_rdata_i = $urandom; #1;
    checks++; if (lsu_err_o !== 1'b1 || lsu_rvalid_o !== 1'b1) begin errors++; $display("FAIL err_pulse got=%b%b want=11", lsu_err_o, lsu_rvalid_o); end
    tick(); idle(); #1;
    checks++; if (lsu_err_o !== 1'b0) begin errors++; $display("FAIL err_clear got=%b want=0", lsu_err_o); end
  endtask

  task automatic test_reset_mid();
    access(1'b0, 2'b00, 1'b0, 32'h300, 32'h0); data_gnt_i = 1'b1;
    tick(); tick(); idle(); #1;
    checks++; if (busy_o !== 1'b1 || lsu_ready_wb_o !== 1'b0) begin errors++; $display("FAIL rstmid_before got=%b%b want=10", busy_o, lsu_ready_wb_o); end
    rst = 1'b1;
    tick(); #1;
    checks++; if (busy_o !== 1'b0 || lsu_ready_wb_o !== 1'b1) begin errors++; $display("FAIL rstmid_after got=%b%b want=01", busy_o, lsu_ready_wb_o); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [1:0]  t   = 2'($urandom_range(0, 2));
      logic [1:0]  off = (t == 2'b00) ? 2'b00 : (t == 2'b01) ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
      logic        we  = 1'($urandom_range(0, 1));
      logic        sgn = 1'($urandom_range(0, 1));
      logic [31:0] a   = {$urandom_range(0, 32'h0FFF_FFFF), 2'b00} | {30'h0, off};
      logic [31:0] w   = $urandom;
      logic [31:0] rd  = $urandom;
      logic [31:0] want;
      int gd = $urandom_range(0, 2);
      int rdl = $urandom_range(0, 2);
      access(we, t, sgn, a, w);
      for (int g = 0; g < gd; g++) begin
        #1;
        checks++; if (data_req_o !== 1'b1 || lsu_ready_ex_o !== 1'b0) begin errors++; $display("FAIL rnd_wait n=%0d got=%b%b want=10", n, data_req_o, lsu_ready_ex_o); end
        tick();
      end
      data_gnt_i = 1'b1; #1;
      checks++;
      if (data_addr_o !== {a[31:2], 2'b00} || data_be_o !== m_be(t, off, 1'b0) ||
          data_we_o !== we || data_wdata_o !== m_wdata(w, off)) begin
        errors++;
        $display("FAIL rnd_req n=%0d got=%h %b %b %h want=%h %b %b %h", n, data_addr_o, data_be_o,
                 data_we_o, data_wdata_o, {a[31:2], 2'b00}, m_be(t, off, 1'b0), we, m_wdata(w, off));
      end
      tick(); idle();
      for (int r = 0; r < rdl; r++) tick();
      data_rvalid_i = 1'b1; data_rdata_i = rd; #1;
      want = we ? 32'h0 : m_load(t, sgn, off, {rd, rd});
      checks++; if (lsu_rvalid_o !== 1'b1 || lsu_rdata_o !== want || lsu_err_o !== 1'b0)
        begin errors++; $display("FAIL rnd_resp n=%0d got=%b/%h/%b want=1/%h/0", n, lsu_rvalid_o, lsu_rdata_o, lsu_err_o, want); end
      tick(); idle();
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_byte_loads();
    test_store_half();
    test_back_to_back();
    test_misaligned();
    test_error();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
